zrb_uart_tx_cfg: RTL



---
 rtl/zrb_uart_pkg.sv | 23 ++
 rtl/zrb_uart_bit_timer.sv | 33 +++
 rtl/zrb_uart_tx_cfg.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/zrb_uart_pkg.sv
// Shared definitions for the zrb UART blocks: parity encodings, FSM states
// and the counter-width helper.
package zrb_uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } uart_state_e;

    // Width needed to count 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/zrb_uart_bit_timer.sv
// Bit-period counter: counts 0..CLK_PER_BIT-1 and wraps, with a synchronous
// clear and a terminal-count tick. Shared by the UART transmitter and receiver.
module zrb_uart_bit_timer
    import zrb_uart_pkg::*;
#(
    parameter  int CLK_PER_BIT = 2604,
    localparam int CNT_W       = cnt_w(CLK_PER_BIT)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tick
);

    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(CLK_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr || (r_cnt == CNT_END)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_tick = (r_cnt == CNT_END) && !i_clr;

endmodule

// File: rtl/zrb_uart_tx_cfg.sv
// Parametrised UART transmitter with internal bit timer, valid/ready intake,
// done pulse and line-break request.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | line high; ready unless break_req; also last stop cycle
//   S_START  | start bit (tx=0)
//   S_DATA   | DATA_BITS payload bits, LSB first
//   S_PARITY | optional parity bit
//   S_STOP   | STOP_BITS stop bits (tx=1)
//   S_BREAK  | line held low while break_req stays high
module zrb_uart_tx_cfg
    import zrb_uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 2604,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 valid,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 break_req,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = cnt_w(CLK_PER_BIT);
    localparam int BIT_W = cnt_w(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_EARLY = CNT_W'(CLK_PER_BIT - 2);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    if (CLK_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2
        || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
        $error("zrb_uart_tx_cfg: illegal parameter combination");
    end

    uart_state_e          r_state, w_state_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [BIT_W-1:0]     r_bit_cnt, w_bit_nxt;
    logic                 r_par, r_tx, r_done;
    logic                 w_tx_nxt, w_done_nxt, w_accept, w_par_calc;
    logic                 w_tick, w_timer_clr;
    logic [CNT_W-1:0]     w_cnt;

    assign w_timer_clr = (r_state == S_IDLE) || (r_state == S_BREAK);
    assign w_par_calc  = (PARITY == PAR_ODD) ? ~^data : ^data;

    zrb_uart_bit_timer #(.CLK_PER_BIT(CLK_PER_BIT)) u_bit_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_timer_clr),
        .o_cnt   (w_cnt),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_tx      <= w_tx_nxt;
            r_done    <= w_done_nxt;
            if (w_accept) begin
                r_par <= w_par_calc;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit_cnt;
        w_done_nxt  = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (break_req) begin
                    w_state_nxt = S_BREAK;
                end else if (valid) begin
                    w_accept    = 1'b1;
                    w_shift_nxt = data;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_tick) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_bit_cnt == LAST_DATA) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_nxt   = r_bit_cnt + 1'b1;
                        w_shift_nxt = r_shift >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                // The final stop cycle is spent in IDLE so done and ready
                // coincide with it and back-to-back frames have no gap.
                if (r_bit_cnt == LAST_STOP) begin
                    if (w_cnt == CNT_EARLY) begin
                        w_bit_nxt   = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_tick) begin
                    w_bit_nxt = r_bit_cnt + 1'b1;
                end
            end
            S_BREAK: begin
                if (!break_req) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        case (w_state_nxt)
            S_START, S_BREAK: w_tx_nxt = 1'b0;
            S_DATA:           w_tx_nxt = w_shift_nxt[0];
            S_PARITY:         w_tx_nxt = r_par;
            default:          w_tx_nxt = 1'b1;
        endcase
    end

    assign ready = (r_state == S_IDLE) && !break_req;
    assign busy  = (r_state != S_IDLE);
    assign tx    = r_tx;
    assign done  = r_done;

endmodule
